hub75_scan_scheduler: RTL and testbench
=======================================

// Module: hub75_scan_scheduler
// PURPOSE
//  Sequences HUB75 panel scan-out: issues row/bit-plane shift requests to the pixel shifter,
//  then drives latch, address and OE with binary-coded-modulation (BCM) display times.
//  Owns the frame-buffer double-buffer select and applies write-side swap requests only at
//  frame boundaries. Sits between the frame RAM read path/shifter and the panel control pins.
// PARAMETERS
//  ROW_BITS        4   panel address width; rows per frame = 2**ROW_BITS
//  PLANE_BITS      2   bit-plane index width; planes per line = 2**PLANE_BITS
//  BASE_OE_CYCLES  8   OE-low cycles for plane 0 at full brightness
//  BLANK_CYCLES    2   OE-high guard cycles before each latch/address change (>=1)
// PORTS
//  clk         in   1           system clock; all logic on rising edge
//  reset       in   1           asynchronous, active-high
//  enable      in   1           run scan; sampled in IDLE and at frame end
//  brightness  in   8           global dimming, sampled at each latch
//  swap_req    in   1           1-cycle pulse: writer finished a buffer
//  swap_ack    out  1           1-cycle pulse when the swap is applied
//  buf_sel     out  1           frame buffer currently read for scan-out
//  line_start  out  1           1-cycle pulse: shifter loads line_row/line_plane
//  line_row    out  ROW_BITS    row to shift; stable from line_start until line_done
//  line_plane  out  PLANE_BITS  bit-plane to shift; same stability
//  line_done   in   1           1-cycle pulse from shifter: line fully clocked out
//  hub75_latch out  1           panel latch, active-high
//  hub75_oe    out  1           panel output enable, active-low (1 = blank)
//  hub75_addr  out  ROW_BITS    panel row address
//  frame_start out  1           1-cycle pulse with line_start of row 0/plane 0
// BEHAVIOUR
//  Reset: oe=1, latch=0, addr=0, buf_sel=0, line_start=0, swap_ack=0, frame_start=0,
//   row/plane counters=0, swap_pending=0, state=IDLE. Async assert, sync deassert.
//   Reset mid-line forces oe=1 immediately; an in-flight line_done is ignored.
//  Scan order: plane inner (0..max), row outer; frame end = last row, last plane.
//  States: IDLE -> SHIFT -> BLANK -> LATCH -> DISPLAY -> (SHIFT | BLANK | IDLE).
//   IDLE: oe=1. enable=1 -> pulse line_start (+frame_start) for row0/plane0, go SHIFT.
//   SHIFT: wait line_done (cycles unbounded); then BLANK.
//   BLANK: oe=1 for BLANK_CYCLES cycles, then LATCH.
//   LATCH: 1 cycle; latch=1, hub75_addr<=line_row of the shifted line, compute
//    oe_len = ((BASE_OE_CYCLES << plane) * (brightness+1)) >> 8 (full-width product,
//    no truncation before shift); advance row/plane; then DISPLAY.
//   DISPLAY: oe=0 exactly oe_len cycles (oe_len==0: oe stays 1, 0 cycles).
//    At end: at frame end with enable=0 -> IDLE (oe=1); otherwise next line handled per
//    overlap mode below.
//  Swap: swap_req sets swap_pending (multiple requests before boundary = one swap).
//   At the line_start of row0/plane0, if pending: buf_sel toggles, swap_ack pulses that
//   cycle, pending clears. swap_req in that same cycle is taken as new pending.
//  Never changes hub75_addr while oe=0; latch never coincides with oe=0.
//  line_done outside SHIFT (or outside wait in overlap mode) is ignored.
// CONFIGURATION
//  HUB75_SCHED_OVERLAP_EN defined: the next line_start is issued in the LATCH cycle, so
//   shifting overlaps DISPLAY; after DISPLAY, go BLANK if line_done already seen,
//   else wait (oe=1) for it. Row0/plane0 line_start at frame wrap obeys the same timing.
//  Not defined: line_start issued in the cycle after DISPLAY ends, then SHIFT
//   (serial, lower throughput, no overlap).
// TESTING  (ROW_BITS=4, PLANE_BITS=2, BASE_OE_CYCLES=8, BLANK_CYCLES=2)
//  Reset asserted mid-DISPLAY -> oe=1, latch=0, addr=0, buf_sel=0 same cycle; restart row0/plane0.
//  brightness=255, line_done 3 cycles after line_start -> oe low 8/16/32/64 cycles for planes 0..3.
//  brightness=127 -> plane 3 oe low 32 cycles; brightness=0 -> plane 0 oe low 0 cycles, latch still pulses.
//  Row 15/plane 3 completes -> next line_start row0/plane0 with frame_start=1; addr only changes while oe=1.
//  Two swap_req pulses mid-frame -> buf_sel toggles once with next frame_start, one swap_ack pulse.
//  OVERLAP_EN on: line_start coincides with latch; off: line_start 1 cycle after oe returns high.

Source files
------------

// File: rtl/hub75_scan_scheduler.sv
// HUB75 scan sequencer: shift request, blank, latch and BCM-timed OE per row/bit-plane, plus
// frame-boundary double-buffer swap. Define HUB75_SCHED_OVERLAP_EN to overlap shifting with DISPLAY.
module hub75_scan_scheduler #(
    parameter int ROW_BITS       = 4,
    parameter int PLANE_BITS     = 2,
    parameter int BASE_OE_CYCLES = 8,
    parameter int BLANK_CYCLES   = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [7:0]            brightness,
    input  logic                  swap_req,
    output logic                  swap_ack,
    output logic                  buf_sel,
    output logic                  line_start,
    output logic [ROW_BITS-1:0]   line_row,
    output logic [PLANE_BITS-1:0] line_plane,
    input  logic                  line_done,
    output logic                  hub75_latch,
    output logic                  hub75_oe,
    output logic [ROW_BITS-1:0]   hub75_addr,
    output logic                  frame_start
);
    // Wide enough for the unshifted BASE << plane * 256 product.
    localparam int LEN_W = $clog2(BASE_OE_CYCLES + 1) + (2 ** PLANE_BITS) - 1 + 9;

    typedef enum logic [2:0] {S_IDLE, S_SHIFT, S_BLANK, S_LATCH, S_DISPLAY} state_t;

    state_t                state_q, state_d;
    logic [ROW_BITS-1:0]   row_q, row_d, addr_q, addr_d;
    logic [PLANE_BITS-1:0] plane_q, plane_d;
    logic [LEN_W-1:0]      cnt_q, cnt_d, base_sh, prod, oe_len;
    logic oe_q, oe_d, latch_q, latch_d, line_start_q, line_start_d;
    logic frame_start_q, frame_start_d, swap_ack_q, swap_ack_d;
    logic buf_sel_q, buf_sel_d, pending_q, pending_d;
    logic issue, issue_first, frame_end;
`ifdef HUB75_SCHED_OVERLAP_EN
    logic done_seen_q, done_seen_d;
`endif

    always_comb begin
        base_sh = LEN_W'(BASE_OE_CYCLES) << plane_q;
        prod    = base_sh * (LEN_W'(brightness) + LEN_W'(1));
        oe_len  = prod >> 8;
    end

    // row_q/plane_q name the line at the shifter; they advance on entry to LATCH.
    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        plane_d     = plane_q;
        cnt_d       = cnt_q;
        oe_d        = oe_q;
        latch_d     = 1'b0;
        addr_d      = addr_q;
        issue       = 1'b0;
        issue_first = 1'b0;
        frame_end   = (row_q == '0) && (plane_q == '0);
        unique case (state_q)
            S_IDLE: begin
                oe_d = 1'b1;
                if (enable) begin
                    issue       = 1'b1;
                    issue_first = 1'b1;
                    state_d     = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (line_done) begin
                    cnt_d   = LEN_W'(BLANK_CYCLES - 1);
                    state_d = S_BLANK;
                end
            end
            S_BLANK: begin
                if (cnt_q == '0) begin
                    latch_d = 1'b1;
                    addr_d  = row_q;
                    cnt_d   = oe_len;
                    state_d = S_LATCH;
                    if (&plane_q) begin
                        plane_d = '0;
                        row_d   = row_q + 1'b1;
                    end else begin
                        plane_d = plane_q + 1'b1;
                    end
`ifdef HUB75_SCHED_OVERLAP_EN
                    issue       = 1'b1;
                    issue_first = (&row_q) && (&plane_q);
`endif
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_LATCH: begin
                oe_d    = (cnt_q == '0);
                state_d = S_DISPLAY;
            end
            S_DISPLAY: begin
                // OE-low for cnt cycles, then one OE-high cycle before moving on.
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                    oe_d  = (cnt_q == LEN_W'(1));
                end else begin
                    oe_d = 1'b1;
                    if (frame_end && !enable) begin
                        state_d = S_IDLE;
                    end else begin
`ifdef HUB75_SCHED_OVERLAP_EN
                        cnt_d   = LEN_W'(BLANK_CYCLES - 1);
                        state_d = (done_seen_q || line_done) ? S_BLANK : S_SHIFT;
`else
                        issue       = 1'b1;
                        issue_first = frame_end;
                        state_d     = S_SHIFT;
`endif
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        line_start_d  = issue;
        frame_start_d = issue && issue_first;
        swap_ack_d    = 1'b0;
        buf_sel_d     = buf_sel_q;
        pending_d     = pending_q | swap_req;
        if (issue && issue_first && (pending_q || swap_req)) begin
            buf_sel_d  = ~buf_sel_q;
            swap_ack_d = 1'b1;
            pending_d  = 1'b0;
        end
`ifdef HUB75_SCHED_OVERLAP_EN
        done_seen_d = done_seen_q | (line_done && (state_q == S_LATCH || state_q == S_DISPLAY));
        if (state_d != S_LATCH && state_d != S_DISPLAY) done_seen_d = 1'b0;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            row_q         <= '0;
            plane_q       <= '0;
            cnt_q         <= '0;
            oe_q          <= 1'b1;
            latch_q       <= 1'b0;
            addr_q        <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            swap_ack_q    <= 1'b0;
            buf_sel_q     <= 1'b0;
            pending_q     <= 1'b0;
`ifdef HUB75_SCHED_OVERLAP_EN
            done_seen_q   <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            row_q         <= row_d;
            plane_q       <= plane_d;
            cnt_q         <= cnt_d;
            oe_q          <= oe_d;
            latch_q       <= latch_d;
            addr_q        <= addr_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            swap_ack_q    <= swap_ack_d;
            buf_sel_q     <= buf_sel_d;
            pending_q     <= pending_d;
`ifdef HUB75_SCHED_OVERLAP_EN
            done_seen_q   <= done_seen_d;
`endif
        end
    end

    assign hub75_oe    = oe_q;
    assign hub75_latch = latch_q;
    assign hub75_addr  = addr_q;
    assign line_start  = line_start_q;
    assign line_row    = row_q;
    assign line_plane  = plane_q;
    assign frame_start = frame_start_q;
    assign swap_ack    = swap_ack_q;
    assign buf_sel     = buf_sel_q;
endmodule

// File: tb/tb_hub75_scan_scheduler.sv
// Bench for hub75_scan_scheduler: a shifter stub answers line_start, and a monitor checks scan
// order, BCM OE lengths, latch/addr safety and buffer swaps against a line-level model.
module tb_hub75_scan_scheduler;
    localparam int RB = 4, PB = 2, BASE = 8, BLANK = 2;

    logic clk = 0, reset = 1, enable = 0, swap_req = 0, line_done = 0;
    logic [7:0] brightness = 8'd255;
    logic swap_ack, buf_sel, line_start, hub75_latch, hub75_oe, frame_start;
    logic [RB-1:0] line_row, hub75_addr;
    logic [PB-1:0] line_plane;

    always #5 clk = ~clk;

    hub75_scan_scheduler #(.ROW_BITS(RB), .PLANE_BITS(PB), .BASE_OE_CYCLES(BASE),
                           .BLANK_CYCLES(BLANK)) dut (
        .clk(clk), .reset(reset), .enable(enable), .brightness(brightness),
        .swap_req(swap_req), .swap_ack(swap_ack), .buf_sel(buf_sel),
        .line_start(line_start), .line_row(line_row), .line_plane(line_plane),
        .line_done(line_done), .hub75_latch(hub75_latch), .hub75_oe(hub75_oe),
        .hub75_addr(hub75_addr), .frame_start(frame_start));

    int total = 0, bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        total++;
        assert (obs === want) else begin
            bad++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, want);
        end
    endtask

    // Shifter stub: line_done pulses a fixed or random number of cycles after line_start.
    bit sh_rand = 0, sh_busy = 0;
    int sh_cnt = 0;
    initial begin
        forever begin
            @(posedge clk); #2;
            line_done = 0;
            if (reset) sh_busy = 0;
            else begin
                if (sh_busy) begin
                    sh_cnt--;
                    if (sh_cnt == 0) begin line_done = 1; sh_busy = 0; end
                end
                if (line_start) begin
                    sh_busy = 1;
                    sh_cnt  = sh_rand ? int'($urandom_range(1, 12)) : 3;
                end
            end
        end
    end

    // Line-level reference model.
    typedef struct {int row; int plane;} line_t;
    line_t q[$];
    line_t ml;
    int cyc = 0, exp_row = 0, exp_plane = 0, latch_cyc = 0, done_cyc = 0, low_cnt = 0;
    int exp_len = 0, ack_cnt = 0, bval;
    bit have_len = 0, have_latch = 0, m_pend = 0, m_buf = 0, restart = 0;
    logic prev_oe = 1'b1;
    logic [RB-1:0] prev_addr = '0;

    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            q.delete();
            exp_row = 0; exp_plane = 0; have_len = 0; have_latch = 0;
            low_cnt = 0; m_pend = 0; m_buf = 0;
        end else begin
            if (!hub75_oe) low_cnt++;
            if (hub75_addr != prev_addr) chk("addr_chg_oe", {31'd0, prev_oe & hub75_oe}, 1);
            if (line_done) done_cyc = cyc;
            if (swap_ack) begin ack_cnt++; chk("ack_with_fs", frame_start, 1); end
            if (frame_start) chk("fs_with_ls", line_start, 1);
            if (hub75_latch) begin
                chk("latch_oe", hub75_oe, 1);
                if (have_len) chk("oe_len", low_cnt, exp_len);
`ifdef HUB75_SCHED_OVERLAP_EN
                chk("ls_with_latch", line_start, 1);
`else
                chk("blank_len", cyc - done_cyc, BLANK + 1);
`endif
                chk("latch_has_line", q.size() > 0, 1);
                if (q.size() > 0) begin
                    ml = q.pop_front();
                    chk("addr", hub75_addr, ml.row);
                    bval = int'(brightness);
                    exp_len = ((BASE << ml.plane) * (bval + 1)) >> 8;
                    have_len = 1;
                end
                low_cnt = 0; latch_cyc = cyc; have_latch = 1;
            end
            if (line_start) begin
`ifdef HUB75_SCHED_OVERLAP_EN
                if (!hub75_latch) begin
                    chk("restart_fs", frame_start, 1);
                    q.delete(); exp_row = 0; exp_plane = 0;
                end
`else
                if (have_latch && !restart) chk("ls_gap", cyc - latch_cyc, exp_len + 2);
                restart = 0;
`endif
                chk("line_row", line_row, exp_row);
                chk("line_plane", line_plane, exp_plane);
                chk("frame_start", frame_start, (exp_row == 0 && exp_plane == 0));
                if (frame_start) begin
                    chk("swap_ack", swap_ack, m_pend);
                    if (m_pend) m_buf = ~m_buf;
                    m_pend = 0;
                end
                chk("buf_sel", buf_sel, m_buf);
                q.push_back('{exp_row, exp_plane});
                if (exp_plane == (1 << PB) - 1) begin
                    exp_plane = 0; exp_row = (exp_row + 1) % (1 << RB);
                end else exp_plane++;
            end
            if (swap_req) m_pend = 1;
        end
        prev_oe = hub75_oe; prev_addr = hub75_addr;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_frame(input int budget);
        int n = 0;
        do begin step(1); n++; end while (!frame_start && n < budget);
        chk("frame_wait", frame_start, 1);
    endtask

    task automatic pulse_swap();
        swap_req = 1; step(1); swap_req = 0;
    endtask

    bit seen;
    int n;
    initial begin
        step(3);
        chk("rst_oe", hub75_oe, 1);
        chk("rst_latch", hub75_latch, 0);
        chk("rst_addr", hub75_addr, 0);
        chk("rst_buf", buf_sel, 0);
        chk("rst_ls", line_start, 0);
        chk("rst_ack", swap_ack, 0);
        chk("rst_fs", frame_start, 0);
        reset = 0;
        enable = 1;
        wait_frame(10);
        chk("f1_ack", swap_ack, 0);
        // Frame at full brightness with two swap requests mid-frame.
        step(500); pulse_swap(); step(300); pulse_swap();
        ack_cnt = 0;
        wait_frame(8000);
        chk("swap_buf", buf_sel, 1);
        chk("swap_ack_pulse", swap_ack, 1);
        step(1);
        brightness = 8'd127;
        wait_frame(8000);
        chk("one_ack", ack_cnt, 1);
        step(1);
        brightness = 8'd0;
        wait_frame(8000);
        step(1);
        sh_rand = 1;
        for (int f = 0; f < 3; f++) begin
            brightness = 8'($urandom);
            wait_frame(8000);
            step(1);
        end
        // Drop enable: current frame completes, then the scheduler idles with OE high.
        brightness = 8'd0;
        enable = 0;
        step(1500);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (line_start || !hub75_oe) seen = 1;
            step(1);
        end
        chk("idle_quiet", seen, 0);
        restart = 1;
        enable = 1;
        n = 0;
        do begin step(1); n++; end while (!line_start && n < 5);
        chk("idle_restart_fs", frame_start, 1);
        // Reset asserted mid-DISPLAY with buf_sel=1 and a non-zero address.
        brightness = 8'd255;
        n = 0;
        do begin step(1); n++; end while (!(!hub75_oe && hub75_addr != 0) && n < 8000);
        chk("disp_reached", {31'd0, !hub75_oe && hub75_addr != 0}, 1);
        chk("pre_rst_buf", buf_sel, 1);
        #2 reset = 1;
        #1;
        chk("mid_rst_oe", hub75_oe, 1);
        chk("mid_rst_latch", hub75_latch, 0);
        chk("mid_rst_addr", hub75_addr, 0);
        chk("mid_rst_buf", buf_sel, 0);
        step(2);
        reset = 0;
        n = 0;
        do begin step(1); n++; end while (!line_start && n < 5);
        chk("post_rst_ls", line_start, 1);
        chk("post_rst_row", line_row, 0);
        chk("post_rst_plane", line_plane, 0);
        chk("post_rst_fs", frame_start, 1);
        wait_frame(8000);
        step(5);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
